// File: rtl/datapath_core_if.sv
// ---------------------------------------------------------------------------
// datapath_core_if
//   Bundles every signal passed between the processor control FSM and the
//   execution datapath. Clock and reset are not part of the bundle.
//
//   master : control FSM side. It drives the register-file, ALU and PC
//            controls and observes the read data, ALU result/flags and PC.
//   slave  : datapath side (datapath_core).
//
//   Signals
//     read_en, ra_num, rb_num        register-file read request
//     write_en, rc_num, wr_data      register-file write request
//     reg_a_data, reg_b_data         registered read-port data
//     operand_a, operand_b, alu_fsl  ALU operands and function select
//     result_low, mul_high, alu_sreg ALU result bytes and flags {V,S,C,Z}
//     jump, jump_line, hold          PC control
//     pc_current, pc_next            PC register and its next value
// ---------------------------------------------------------------------------
interface datapath_core_if;
  logic       read_en;
  logic       write_en;
  logic [2:0] ra_num;
  logic [2:0] rb_num;
  logic [2:0] rc_num;
  logic [7:0] wr_data;
  logic [7:0] reg_a_data;
  logic [7:0] reg_b_data;
  logic [7:0] operand_a;
  logic [7:0] operand_b;
  logic [3:0] alu_fsl;
  logic [7:0] result_low;
  logic [7:0] mul_high;
  logic [3:0] alu_sreg;
  logic       jump;
  logic [7:0] jump_line;
  logic       hold;
  logic [7:0] pc_current;
  logic [7:0] pc_next;

  modport master (
    output read_en, write_en, ra_num, rb_num, rc_num, wr_data,
    output operand_a, operand_b, alu_fsl,
    output jump, jump_line, hold,
    input  reg_a_data, reg_b_data,
    input  result_low, mul_high, alu_sreg,
    input  pc_current, pc_next
  );

  modport slave (
    input  read_en, write_en, ra_num, rb_num, rc_num, wr_data,
    input  operand_a, operand_b, alu_fsl,
    input  jump, jump_line, hold,
    output reg_a_data, reg_b_data,
    output result_low, mul_high, alu_sreg,
    output pc_current, pc_next
  );
endinterface

// File: rtl/datapath_core.sv
// ---------------------------------------------------------------------------
// datapath_core
//   Execution datapath of the 8-bit core: a combinational 16-function ALU,
//   an 8 x 8-bit register file (two registered read ports, one write port
//   plus the MUL high-byte write) and the 8-bit program counter.
//
//   Ports
//     clk    system clock, all state changes on the rising edge
//     rst_n  synchronous active-low reset; clears registers, read ports, PC
//     bus    datapath_core_if.slave (see the interface for the signal list)
//
//   Configuration
//     DATAPATH_MUL_EN  when defined, function 1000 is an unsigned 8x8 multiply
//                      whose high byte is also written to R[rc_num+1].
//                      When undefined, function 1000 yields zero with only
//                      Z set, and no multiplier is built.
// ---------------------------------------------------------------------------
module datapath_core (
  input  logic             clk,
  input  logic             rst_n,
  datapath_core_if.slave   bus
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_NOT  = 4'b0101,
    OP_SHL  = 4'b0110,
    OP_SHR  = 4'b0111,
    OP_MUL  = 4'b1000,
    OP_INC  = 4'b1001,
    OP_DEC  = 4'b1010,
    OP_NAND = 4'b1011,
    OP_NOR  = 4'b1100,
    OP_ROL  = 4'b1101,
    OP_ROR  = 4'b1110,
    OP_CMP  = 4'b1111
  } aluOp_e;

  logic [7:0] regFile [8];
  logic [7:0] regA;
  logic [7:0] regB;
  logic [7:0] pcReg;
  logic [7:0] pcNext;

  logic [7:0] opA;
  logic [7:0] opB;
  logic [8:0] sumAB;
  logic [8:0] diffAB;
  logic [8:0] incA;
  logic [8:0] decA;
  logic [7:0] resultLow;
  logic [7:0] mulHigh;
  logic       carryFlag;
  logic       overflowFlag;
  logic       zeroFlag;
  logic       signFlag;

  assign opA    = bus.operand_a;
  assign opB    = bus.operand_b;

  // The ninth bit of each 9-bit sum/difference is the carry or the borrow.
  assign sumAB  = {1'b0, opA} + {1'b0, opB};
  assign diffAB = {1'b0, opA} - {1'b0, opB};
  assign incA   = {1'b0, opA} + 9'd1;
  assign decA   = {1'b0, opA} - 9'd1;

`ifdef DATAPATH_MUL_EN
  logic [15:0] product;
  assign product = {8'h00, opA} * {8'h00, opB};
`endif

  // ALU: result, carry and overflow per function; Z and S come from the
  // low byte except for MUL, which judges them on the full 16-bit product.
  always_comb begin
    resultLow    = 8'h00;
    mulHigh      = 8'h00;
    carryFlag    = 1'b0;
    overflowFlag = 1'b0;
    case (bus.alu_fsl)
      OP_ADD: begin
        resultLow    = sumAB[7:0];
        carryFlag    = sumAB[8];
        overflowFlag = (opA[7] == opB[7]) && (sumAB[7] != opA[7]);
      end
      OP_SUB, OP_CMP: begin
        resultLow    = diffAB[7:0];
        carryFlag    = diffAB[8];
        overflowFlag = (opA[7] != opB[7]) && (diffAB[7] != opA[7]);
      end
      OP_AND:  resultLow = opA & opB;
      OP_OR:   resultLow = opA | opB;
      OP_XOR:  resultLow = opA ^ opB;
      OP_NOT:  resultLow = ~opA;
      OP_SHL: begin
        resultLow = {opA[6:0], 1'b0};
        carryFlag = opA[7];
      end
      OP_SHR: begin
        resultLow = {1'b0, opA[7:1]};
        carryFlag = opA[0];
      end
      OP_MUL: begin
`ifdef DATAPATH_MUL_EN
        resultLow = product[7:0];
        mulHigh   = product[15:8];
        carryFlag = (product[15:8] != 8'h00);
`else
        resultLow = 8'h00;
        mulHigh   = 8'h00;
`endif
      end
      OP_INC: begin
        resultLow    = incA[7:0];
        carryFlag    = incA[8];
        overflowFlag = (opA == 8'h7F);
      end
      OP_DEC: begin
        resultLow    = decA[7:0];
        carryFlag    = decA[8];
        overflowFlag = (opA == 8'h80);
      end
      OP_NAND: resultLow = ~(opA & opB);
      OP_NOR:  resultLow = ~(opA | opB);
      OP_ROL: begin
        resultLow = {opA[6:0], opA[7]};
        carryFlag = opA[7];
      end
      OP_ROR: begin
        resultLow = {opA[0], opA[7:1]};
        carryFlag = opA[0];
      end
      default: resultLow = 8'h00;
    endcase

    zeroFlag = (resultLow == 8'h00);
    signFlag = resultLow[7];
`ifdef DATAPATH_MUL_EN
    if (bus.alu_fsl == OP_MUL) begin
      zeroFlag = (product == 16'h0000);
      signFlag = product[15];
    end
`endif
  end

  assign bus.result_low = resultLow;
  assign bus.mul_high   = mulHigh;
  assign bus.alu_sreg   = {overflowFlag, signFlag, carryFlag, zeroFlag};

  // Register file. Reads sample the array before this edge's write lands,
  // so a same-edge read and write of one register returns the old value.
  // A MUL writeback also drops the high byte into the next register up,
  // wrapping R7 -> R0 through the 3-bit index arithmetic.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regFile <= '{default: 8'h00};
      regA    <= 8'h00;
      regB    <= 8'h00;
    end else begin
      if (bus.read_en) begin
        regA <= regFile[bus.ra_num];
        regB <= regFile[bus.rb_num];
      end
      if (bus.write_en) begin
        regFile[bus.rc_num] <= bus.wr_data;
`ifdef DATAPATH_MUL_EN
        if (bus.alu_fsl == OP_MUL) begin
          regFile[bus.rc_num + 3'd1] <= mulHigh;
        end
`endif
      end
    end
  end

  assign bus.reg_a_data = regA;
  assign bus.reg_b_data = regB;

  // Program counter: jump beats hold beats increment; 8-bit add wraps 255 -> 0.
  assign pcNext = bus.jump ? bus.jump_line :
                  bus.hold ? pcReg         :
                             pcReg + 8'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcReg <= 8'h00;
    end else begin
      pcReg <= pcNext;
    end
  end

  assign bus.pc_current = pcReg;
  assign bus.pc_next    = pcNext;

endmodule

// File: tb/tb_datapath_core.sv
// ---------------------------------------------------------------------------
// tb_datapath_core
//   Directed bench for datapath_core: reset state, register-file write/read
//   latency and same-edge ordering, every ALU function with its flags, MUL
//   writeback (or its disabled form), and PC increment/wrap/hold/jump.
//   Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_datapath_core;

  logic clk;
  logic rst_n;
  int   vecCount;
  int   missCount;

  datapath_core_if bus ();

  datapath_core dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge, then settle 1 unit so outputs are sampled
  // away from the edge.
  task automatic stepClk(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive ALU operands and function, then let the combinational path settle.
  task automatic applyStimulus(input logic [3:0] fsl, input logic [7:0] a,
                               input logic [7:0] b);
    bus.alu_fsl   = fsl;
    bus.operand_a = a;
    bus.operand_b = b;
    #1;
  endtask

  // One comparison; a mismatch counts and reports tag, observed, expected.
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    vecCount++;
    assert (observed === expected)
    else begin
      missCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    vecCount      = 0;
    missCount     = 0;
    rst_n         = 1'b0;
    bus.read_en   = 1'b0;
    bus.write_en  = 1'b0;
    bus.ra_num    = 3'd0;
    bus.rb_num    = 3'd0;
    bus.rc_num    = 3'd0;
    bus.wr_data   = 8'h00;
    bus.operand_a = 8'h00;
    bus.operand_b = 8'h00;
    bus.alu_fsl   = 4'b0000;
    bus.jump      = 1'b0;
    bus.jump_line = 8'h00;
    bus.hold      = 1'b1;

    // Reset
    stepClk(1);
    checkOutput("reset_pc", {8'h00, bus.pc_current}, 16'h0000);
    checkOutput("reset_rega", {8'h00, bus.reg_a_data}, 16'h0000);
    checkOutput("reset_regb", {8'h00, bus.reg_b_data}, 16'h0000);
    rst_n = 1'b1;

    // Write R3=0x7F, R5=0x01, then read them back
    bus.write_en = 1'b1;
    bus.rc_num   = 3'd3;
    bus.wr_data  = 8'h7F;
    stepClk(1);
    bus.rc_num   = 3'd5;
    bus.wr_data  = 8'h01;
    stepClk(1);
    bus.write_en = 1'b0;
    bus.read_en  = 1'b1;
    bus.ra_num   = 3'd3;
    bus.rb_num   = 3'd5;
    stepClk(1);
    checkOutput("read_r3", {8'h00, bus.reg_a_data}, 16'h007F);
    checkOutput("read_r5", {8'h00, bus.reg_b_data}, 16'h0001);
    bus.read_en  = 1'b0;

    // ALU functions: result_low, then flags {V,S,C,Z}
    applyStimulus(4'b0000, 8'h7F, 8'h01);
    checkOutput("add_ovf_res", {8'h00, bus.result_low}, 16'h0080);
    checkOutput("add_ovf_flg", {12'h000, bus.alu_sreg}, 16'h000C);
    checkOutput("add_mulhigh", {8'h00, bus.mul_high}, 16'h0000);
    applyStimulus(4'b0000, 8'hFF, 8'h01);
    checkOutput("add_carry_res", {8'h00, bus.result_low}, 16'h0000);
    checkOutput("add_carry_flg", {12'h000, bus.alu_sreg}, 16'h0003);
    applyStimulus(4'b0001, 8'h10, 8'h20);
    checkOutput("sub_res", {8'h00, bus.result_low}, 16'h00F0);
    checkOutput("sub_flg", {12'h000, bus.alu_sreg}, 16'h0006);
    applyStimulus(4'b0001, 8'h80, 8'h01);
    checkOutput("sub_ovf_res", {8'h00, bus.result_low}, 16'h007F);
    checkOutput("sub_ovf_flg", {12'h000, bus.alu_sreg}, 16'h0008);
    applyStimulus(4'b1111, 8'h42, 8'h42);
    checkOutput("cmp_res", {8'h00, bus.result_low}, 16'h0000);
    checkOutput("cmp_flg", {12'h000, bus.alu_sreg}, 16'h0001);
    applyStimulus(4'b0010, 8'hF0, 8'h3C);
    checkOutput("and_res", {8'h00, bus.result_low}, 16'h0030);
    checkOutput("and_flg", {12'h000, bus.alu_sreg}, 16'h0000);
    applyStimulus(4'b0011, 8'h0A, 8'h50);
    checkOutput("or_res", {8'h00, bus.result_low}, 16'h005A);
    applyStimulus(4'b0100, 8'hFF, 8'hFF);
    checkOutput("xor_res", {8'h00, bus.result_low}, 16'h0000);
    checkOutput("xor_flg", {12'h000, bus.alu_sreg}, 16'h0001);
    applyStimulus(4'b0101, 8'h0F, 8'h00);
    checkOutput("not_res", {8'h00, bus.result_low}, 16'h00F0);
    checkOutput("not_flg", {12'h000, bus.alu_sreg}, 16'h0004);
    applyStimulus(4'b0110, 8'h81, 8'h00);
    checkOutput("shl_res", {8'h00, bus.result_low}, 16'h0002);
    checkOutput("shl_flg", {12'h000, bus.alu_sreg}, 16'h0002);
    applyStimulus(4'b0111, 8'h01, 8'h00);
    checkOutput("shr_res", {8'h00, bus.result_low}, 16'h0000);
    checkOutput("shr_flg", {12'h000, bus.alu_sreg}, 16'h0003);
    applyStimulus(4'b1001, 8'h7F, 8'h00);
    checkOutput("inc_ovf_res", {8'h00, bus.result_low}, 16'h0080);
    checkOutput("inc_ovf_flg", {12'h000, bus.alu_sreg}, 16'h000C);
    applyStimulus(4'b1001, 8'hFF, 8'h00);
    checkOutput("inc_wrap_flg", {12'h000, bus.alu_sreg}, 16'h0003);
    applyStimulus(4'b1010, 8'h00, 8'h00);
    checkOutput("dec_res", {8'h00, bus.result_low}, 16'h00FF);
    checkOutput("dec_flg", {12'h000, bus.alu_sreg}, 16'h0006);
    applyStimulus(4'b1010, 8'h80, 8'h00);
    checkOutput("dec_ovf_flg", {12'h000, bus.alu_sreg}, 16'h0008);
    applyStimulus(4'b1011, 8'hFF, 8'hFF);
    checkOutput("nand_res", {8'h00, bus.result_low}, 16'h0000);
    applyStimulus(4'b1100, 8'h00, 8'h00);
    checkOutput("nor_res", {8'h00, bus.result_low}, 16'h00FF);
    checkOutput("nor_flg", {12'h000, bus.alu_sreg}, 16'h0004);
    applyStimulus(4'b1101, 8'h81, 8'h00);
    checkOutput("rol_res", {8'h00, bus.result_low}, 16'h0003);
    checkOutput("rol_flg", {12'h000, bus.alu_sreg}, 16'h0002);
    applyStimulus(4'b1110, 8'h01, 8'h00);
    checkOutput("ror_res", {8'h00, bus.result_low}, 16'h0080);
    checkOutput("ror_flg", {12'h000, bus.alu_sreg}, 16'h0006);

    // MUL 0xFF*0xFF and writeback to R7 (high byte to R0 when enabled)
    applyStimulus(4'b1000, 8'hFF, 8'hFF);
`ifdef DATAPATH_MUL_EN
    checkOutput("mul_low", {8'h00, bus.result_low}, 16'h0001);
    checkOutput("mul_high", {8'h00, bus.mul_high}, 16'h00FE);
    checkOutput("mul_flg", {12'h000, bus.alu_sreg}, 16'h0006);
`else
    checkOutput("mul_off_low", {8'h00, bus.result_low}, 16'h0000);
    checkOutput("mul_off_high", {8'h00, bus.mul_high}, 16'h0000);
    checkOutput("mul_off_flg", {12'h000, bus.alu_sreg}, 16'h0001);
`endif
    bus.write_en = 1'b1;
    bus.rc_num   = 3'd7;
    bus.wr_data  = 8'h01;
    stepClk(1);
    bus.write_en = 1'b0;
    bus.alu_fsl  = 4'b0000;
    bus.read_en  = 1'b1;
    bus.ra_num   = 3'd7;
    bus.rb_num   = 3'd0;
    stepClk(1);
    checkOutput("mul_wb_r7", {8'h00, bus.reg_a_data}, 16'h0001);
`ifdef DATAPATH_MUL_EN
    checkOutput("mul_wb_r0", {8'h00, bus.reg_b_data}, 16'h00FE);
`else
    checkOutput("mul_off_r0", {8'h00, bus.reg_b_data}, 16'h0000);
`endif

    // Same-edge write R2=0x55 and read R2 returns old value
    bus.write_en = 1'b1;
    bus.rc_num   = 3'd2;
    bus.wr_data  = 8'h55;
    bus.ra_num   = 3'd2;
    stepClk(1);
    checkOutput("same_edge_old", {8'h00, bus.reg_a_data}, 16'h0000);
    bus.write_en = 1'b0;
    stepClk(1);
    checkOutput("same_edge_new", {8'h00, bus.reg_a_data}, 16'h0055);
    bus.read_en  = 1'b0;
    bus.ra_num   = 3'd3;
    stepClk(1);
    checkOutput("read_hold", {8'h00, bus.reg_a_data}, 16'h0055);

    // PC: frozen by hold, then increments and wraps
    checkOutput("pc_held", {8'h00, bus.pc_current}, 16'h0000);
    checkOutput("pc_next_held", {8'h00, bus.pc_next}, 16'h0000);
    bus.hold = 1'b0;
    #1;
    checkOutput("pc_next_inc", {8'h00, bus.pc_next}, 16'h0001);
    stepClk(255);
    checkOutput("pc_ff", {8'h00, bus.pc_current}, 16'h00FF);
    checkOutput("pc_next_wrap", {8'h00, bus.pc_next}, 16'h0000);
    stepClk(1);
    checkOutput("pc_wrap", {8'h00, bus.pc_current}, 16'h0000);
    stepClk(3);
    checkOutput("pc_three", {8'h00, bus.pc_current}, 16'h0003);
    bus.hold = 1'b1;
    stepClk(2);
    checkOutput("pc_freeze", {8'h00, bus.pc_current}, 16'h0003);
    bus.jump      = 1'b1;
    bus.jump_line = 8'h40;
    #1;
    checkOutput("pc_next_jump", {8'h00, bus.pc_next}, 16'h0040);
    stepClk(1);
    checkOutput("pc_jump", {8'h00, bus.pc_current}, 16'h0040);
    bus.jump = 1'b0;
    stepClk(1);
    checkOutput("pc_after_jump", {8'h00, bus.pc_current}, 16'h0040);

    // Reset mid-run clears PC, read ports and the register file
    rst_n = 1'b0;
    stepClk(1);
    checkOutput("rerst_pc", {8'h00, bus.pc_current}, 16'h0000);
    checkOutput("rerst_rega", {8'h00, bus.reg_a_data}, 16'h0000);
    rst_n       = 1'b1;
    bus.read_en = 1'b1;
    bus.ra_num  = 3'd3;
    bus.rb_num  = 3'd2;
    stepClk(1);
    checkOutput("rerst_r3", {8'h00, bus.reg_a_data}, 16'h0000);
    checkOutput("rerst_r2", {8'h00, bus.reg_b_data}, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
